// File: rtl/tpm_pkg.sv
// tpm_pkg: shared route tags and default widths for the SRAM port arbiter
package tpm_pkg;
    localparam int TPM_DATA_WIDTH = 8;
    localparam int TPM_ADDR_WIDTH = 10;
    typedef enum logic [1:0] {ROUTE_NONE, ROUTE_P0, ROUTE_P1, ROUTE_FWD} route_e;
endpackage

// File: rtl/tpm_rr_picker.sv
// tpm_rr_picker: 2-way round-robin winner selection and pointer update
module tpm_rr_picker (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic gnt0,
    output logic gnt1,
    output logic ptr_next
);
    // ptr=0 favours req0; the pointer flips only when both requesters contend
    always_comb begin
        gnt0     = req0 && (!req1 || !ptr);
        gnt1     = req1 && (!req0 || ptr);
        ptr_next = (req0 && req1) ? !ptr : ptr;
    end
endmodule

// File: rtl/tpm_sram_port_arbiter.sv
// tpm_sram_port_arbiter: shares a 1RW+1R SRAM macro among one writer and two readers
// Optional feature macro TPM_WRITE_BYPASS_EN: reads colliding with the write are
// granted and served from a registered copy of the write data instead of stalling.
module tpm_sram_port_arbiter
    import tpm_pkg::*;
#(
    parameter int DATA_WIDTH = TPM_DATA_WIDTH,
    parameter int ADDR_WIDTH = TPM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  mem_csb0,
    output logic                  mem_web0,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic [DATA_WIDTH-1:0] mem_din0,
    input  logic [DATA_WIDTH-1:0] mem_dout0,
    output logic                  mem_csb1,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    input  logic [DATA_WIDTH-1:0] mem_dout1
);
    logic c0, c1, e0, e1, f0, f1, g0, g1, pg0, pg1, wg;
    logic rr_q, rr_d, rr_nx;
    route_e tag0_q, tag0_d, tag1_q, tag1_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d, fwd_data;

    tpm_rr_picker u_pick (
        .req0     (e0),
        .req1     (e1),
        .ptr      (rr_q),
        .gnt0     (pg0),
        .gnt1     (pg1),
        .ptr_next (rr_nx)
    );

    // Classify each read: collides with the write, forwardable, or eligible for a macro port
    always_comb begin
        wg = w_valid && !rst;
        c0 = w_valid && (r0_addr == w_addr);
        c1 = w_valid && (r1_addr == w_addr);
`ifdef TPM_WRITE_BYPASS_EN
        f0 = !rst && r0_valid && c0;
        f1 = !rst && r1_valid && c1;
`else
        f0 = 1'b0;
        f1 = 1'b0;
`endif
        e0 = !rst && r0_valid && !c0;
        e1 = !rst && r1_valid && !c1;
    end

    // Grants, route tags and macro pins; with a write only port1 is free for reads
    always_comb begin
        g0        = w_valid ? pg0 : e0;
        g1        = w_valid ? pg1 : e1;
        rr_d      = w_valid ? rr_nx : rr_q;
        tag0_d    = f0 ? ROUTE_FWD : g0 ? ROUTE_P1 : ROUTE_NONE;
        tag1_d    = f1 ? ROUTE_FWD : (g1 && g0 && !w_valid) ? ROUTE_P0 : g1 ? ROUTE_P1 : ROUTE_NONE;
        w_ready   = !rst;
        r0_ready  = g0 || f0;
        r1_ready  = g1 || f1;
        mem_csb0  = !(wg || tag1_d == ROUTE_P0);
        mem_web0  = !wg;
        mem_csb1  = !(g0 || tag1_d == ROUTE_P1);
        addr0_d   = wg ? w_addr : (tag1_d == ROUTE_P0) ? r1_addr : addr0_q;
        din0_d    = wg ? w_data : din0_q;
        addr1_d   = g0 ? r0_addr : (tag1_d == ROUTE_P1) ? r1_addr : addr1_q;
        mem_addr0 = addr0_d;
        mem_din0  = din0_d;
        mem_addr1 = addr1_d;
        r0_rvalid = tag0_q != ROUTE_NONE;
        r1_rvalid = tag1_q != ROUTE_NONE;
        r0_rdata  = (tag0_q == ROUTE_FWD) ? fwd_data : (tag0_q == ROUTE_P0) ? mem_dout0 : mem_dout1;
        r1_rdata  = (tag1_q == ROUTE_FWD) ? fwd_data : (tag1_q == ROUTE_P0) ? mem_dout0 : mem_dout1;
    end

`ifdef TPM_WRITE_BYPASS_EN
    logic [DATA_WIDTH-1:0] fwd_q, fwd_d;

    // Capture each accepted write so a colliding read can return it next cycle
    always_comb begin
        fwd_d    = wg ? w_data : fwd_q;
        fwd_data = fwd_q;
    end

    // Forward data register
    always_ff @(posedge clk) begin
        if (rst) fwd_q <= '0;
        else     fwd_q <= fwd_d;
    end
`else
    // No forwarding path without the bypass feature
    always_comb fwd_data = '0;
`endif

    // Route tags, round-robin pointer and held idle pin values
    always_ff @(posedge clk) begin
        if (rst) begin
            tag0_q  <= ROUTE_NONE;
            tag1_q  <= ROUTE_NONE;
            rr_q    <= 1'b0;
            addr0_q <= '0;
            addr1_q <= '0;
            din0_q  <= '0;
        end else begin
            tag0_q  <= tag0_d;
            tag1_q  <= tag1_d;
            rr_q    <= rr_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
            din0_q  <= din0_d;
        end
    end
endmodule

// File: tb/tb_tpm_sram_port_arbiter.sv
// tb_tpm_sram_port_arbiter: scoreboard bench with a behavioural 1RW+1R macro model
module tb_tpm_sram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic w_valid = 1'b1, r0_valid = 1'b1, r1_valid = 1'b1;
    logic [9:0] w_addr = 10'h100, r0_addr = 10'h101, r1_addr = 10'h102;
    logic [7:0] w_data = 8'h77;
    logic w_ready, r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [7:0] r0_rdata, r1_rdata;
    logic mem_csb0, mem_web0, mem_csb1;
    logic [9:0] mem_addr0, mem_addr1;
    logic [7:0] mem_din0, mem_dout0, mem_dout1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] mem [0:1023];
    logic       wr_pend = 1'b0;
    logic [9:0] wp_addr;
    logic [7:0] wp_data;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    tpm_sram_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_addr   (r0_addr),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_addr   (r1_addr),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .mem_csb0  (mem_csb0),
        .mem_web0  (mem_web0),
        .mem_addr0 (mem_addr0),
        .mem_din0  (mem_din0),
        .mem_dout0 (mem_dout0),
        .mem_csb1  (mem_csb1),
        .mem_addr1 (mem_addr1),
        .mem_dout1 (mem_dout1)
    );

    // Macro model: pins sampled at posedge, write committed at the following negedge
    always @(posedge clk) begin
        if (!mem_csb0 && mem_web0) mem_dout0 <= mem[mem_addr0];
        if (!mem_csb1) mem_dout1 <= mem[mem_addr1];
        wr_pend <= !mem_csb0 && !mem_web0;
        wp_addr <= mem_addr0;
        wp_data <= mem_din0;
    end

    always @(negedge clk) if (wr_pend) mem[wp_addr] = wp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int rd, input logic [7:0] d);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = d;
        if (rd == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic drive(input logic r, input logic wv, input logic [9:0] wa, input logic [7:0] wd,
                         input logic v0, input logic [9:0] a0, input logic v1, input logic [9:0] a1);
        @(posedge clk);
        #1;
        rst = r;
        w_valid = wv; w_addr = wa; w_data = wd;
        r0_valid = v0; r0_addr = a0;
        r1_valid = v1; r1_addr = a1;
        @(negedge clk);
    endtask

    task automatic chk_rdy(input string name, input logic w, input logic a, input logic b);
        chk({name, " w_ready"}, w_ready, w);
        chk({name, " r0_ready"}, r0_ready, a);
        chk({name, " r1_ready"}, r1_ready, b);
    endtask

    // Monitor: pop the expected response whose due cycle has arrived; flag strays
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            e = q0.pop_front();
            chk("r0 rvalid", r0_rvalid, 1);
            chk("r0 rdata", r0_rdata, e.data);
        end else if (r0_rvalid !== 1'b0) chk("r0 spurious rvalid", r0_rvalid, 0);
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front();
            chk("r1 rvalid", r1_rvalid, 1);
            chk("r1 rdata", r1_rdata, e.data);
        end else if (r1_rvalid !== 1'b0) chk("r1 spurious rvalid", r1_rvalid, 0);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        mem[10'h101] = 8'h5A;
        mem[10'h010] = 8'h11;
        mem[10'h020] = 8'h22;
        mem[10'h011] = 8'h33;
        mem[10'h021] = 8'h44;
        mem[10'h0AA] = 8'h00;
        mem[10'h030] = 8'h66;

        // reset held with every requester valid
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 10'h100, 8'h77, 1, 10'h101, 1, 10'h102);
            chk_rdy("reset", 0, 0, 0);
            chk("reset csb0", mem_csb0, 1);
            chk("reset web0", mem_web0, 1);
            chk("reset csb1", mem_csb1, 1);
        end
        drive(0, 1, 10'h100, 8'h77, 1, 10'h101, 1, 10'h102);
        chk_rdy("first grant", 1, 1, 0);
        chk("first grant csb1", mem_csb1, 0);
        chk("first grant addr1", mem_addr1, 10'h101);
        chk("first grant csb0", mem_csb0, 0);
        push(0, 8'h5A);

        // write then read-after-write
        drive(0, 1, 10'h005, 8'hA5, 0, 0, 0, 0);
        chk("raw csb0", mem_csb0, 0);
        chk("raw web0", mem_web0, 0);
        chk("raw addr0", mem_addr0, 10'h005);
        chk("raw din0", mem_din0, 8'hA5);
        chk("raw csb1", mem_csb1, 1);
        drive(0, 0, 0, 0, 1, 10'h005, 0, 0);
        chk("raw r0_ready", r0_ready, 1);
        push(0, 8'hA5);

        // dual read with no write: R0 on port1, R1 on port0
        drive(0, 0, 0, 0, 1, 10'h010, 1, 10'h020);
        chk_rdy("dual", 1, 1, 1);
        chk("dual csb0", mem_csb0, 0);
        chk("dual web0", mem_web0, 1);
        chk("dual addr0", mem_addr0, 10'h020);
        chk("dual csb1", mem_csb1, 0);
        chk("dual addr1", mem_addr1, 10'h010);
        push(0, 8'h11);
        push(1, 8'h22);

        // contention: pointer back to R0 via a reset cycle, then alternate
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 10'h200 + 10'(i), 8'h40 + 8'(i), 1, 10'h011, 1, 10'h021);
            chk("contend r0_ready", r0_ready, (i % 2 == 0));
            chk("contend r1_ready", r1_ready, (i % 2 == 1));
            chk("contend csb0", mem_csb0, 0);
            chk("contend web0", mem_web0, 0);
            if (i % 2 == 0) push(0, 8'h33);
            else            push(1, 8'h44);
        end

        // collision of R0 with the write
        drive(0, 1, 10'h0AA, 8'h3C, 1, 10'h0AA, 0, 0);
        chk("collide csb1", mem_csb1, 1);
        chk("collide csb0", mem_csb0, 0);
`ifdef TPM_WRITE_BYPASS_EN
        chk("collide r0_ready", r0_ready, 1);
        push(0, 8'h3C);
`else
        chk("collide r0_ready", r0_ready, 0);
        drive(0, 0, 0, 0, 1, 10'h0AA, 0, 0);
        chk("retry r0_ready", r0_ready, 1);
        push(0, 8'h3C);
`endif

        // R0 collides while R1 reads elsewhere through port1
        drive(0, 1, 10'h0BB, 8'h9E, 1, 10'h0BB, 1, 10'h010);
        chk("mixed r1_ready", r1_ready, 1);
        chk("mixed csb1", mem_csb1, 0);
        chk("mixed addr1", mem_addr1, 10'h010);
        push(1, 8'h11);
`ifdef TPM_WRITE_BYPASS_EN
        chk("mixed r0_ready", r0_ready, 1);
        push(0, 8'h9E);
`else
        chk("mixed r0_ready", r0_ready, 0);
`endif

        // reset rising in the cycle R1 requests
        drive(1, 0, 0, 0, 0, 0, 1, 10'h030);
        chk("midrst r1_ready", r1_ready, 0);
        chk("midrst csb0", mem_csb0, 1);
        chk("midrst csb1", mem_csb1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("midrst r1_rvalid", r1_rvalid, 0);
        chk("post rst csb0", mem_csb0, 1);
        chk("post rst csb1", mem_csb1, 1);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0 responses outstanding", q0.size(), 0);
        chk("r1 responses outstanding", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
